// File: rtl/sdio_crc_lanes_if.sv
// Bus bundle for sdio_crc_lanes: block control, serial lanes and status.
// err_count is present only when SDIO_CRC_ERR_COUNT_EN is defined.
interface sdio_crc_lanes_if #(
    parameter int LANES     = 4,
    parameter int CRC_WIDTH = 16,
    parameter int LEN_W     = 13
) ();
    logic                       start;
    logic                       mode;
    logic [LEN_W-1:0]           block_len;
    logic                       en;
    logic [LANES-1:0]           din;
    logic [LANES-1:0]           dout;
    logic                       dout_valid;
    logic                       busy;
    logic                       done;
    logic [LANES-1:0]           crc_err;
    logic [LANES*CRC_WIDTH-1:0] crc;
`ifdef SDIO_CRC_ERR_COUNT_EN
    logic [7:0]                 err_count;
`endif

    modport master (
        output start, mode, block_len, en, din,
        input  dout, dout_valid, busy, done, crc_err, crc
`ifdef SDIO_CRC_ERR_COUNT_EN
        , input err_count
`endif
    );

    modport slave (
        input  start, mode, block_len, en, din,
        output dout, dout_valid, busy, done, crc_err, crc
`ifdef SDIO_CRC_ERR_COUNT_EN
        , output err_count
`endif
    );
endinterface

// File: rtl/sdio_crc_lanes.sv
// Multi-lane serial CRC engine: per-lane LFSR, block sequencing, CRC generate or check.
// Optional saturating failed-block counter enabled by SDIO_CRC_ERR_COUNT_EN.
module sdio_crc_lanes #(
    parameter int                   LANES      = 4,
    parameter int                   CRC_WIDTH  = 16,
    parameter logic [CRC_WIDTH-1:0] POLYNOMIAL = 16'h1021,
    parameter logic [CRC_WIDTH-1:0] SEED       = '0,
    parameter int                   LEN_W      = 13
) (
    input logic              clk,
    input logic              rst_n,
    sdio_crc_lanes_if.slave  bus
);
    localparam int SH_W = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StData, StCrc} state_t;

    state_t                 state_q, state_d;
    logic [CRC_WIDTH-1:0]   crc_q [LANES];
    logic [CRC_WIDTH-1:0]   crc_d [LANES];
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [SH_W-1:0]        sh_q, sh_d;
    logic                   mode_q, mode_d;
    logic [LANES-1:0]       err_q, err_d;
    logic                   done_q, done_d;

    function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c,
                                                      input logic b);
        logic fb;
        fb = b ^ c[CRC_WIDTH-1];
        return {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLYNOMIAL : '0);
    endfunction

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sh_d    = sh_q;
        mode_d  = mode_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    for (int k = 0; k < LANES; k++) crc_d[k] = SEED;
                    err_d   = '0;
                    cnt_d   = '0;
                    sh_d    = '0;
                    len_d   = bus.block_len;
                    mode_d  = bus.mode;
                    state_d = (bus.block_len == '0) ? StCrc : StData;
                end
            end
            StData: begin
                if (bus.en) begin
                    for (int k = 0; k < LANES; k++) crc_d[k] = crc_step(crc_q[k], bus.din[k]);
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        cnt_d   = '0;
                        sh_d    = '0;
                        state_d = StCrc;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            StCrc: begin
                if (bus.en) begin
                    // Compare against the outgoing MSB before it is shifted away.
                    for (int k = 0; k < LANES; k++) begin
                        err_d[k] = err_q[k] | (mode_q & (bus.din[k] ^ crc_q[k][CRC_WIDTH-1]));
                        crc_d[k] = {crc_q[k][CRC_WIDTH-2:0], 1'b0};
                    end
                    if (sh_q == SH_W'(CRC_WIDTH - 1)) begin
                        sh_d    = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        sh_d = sh_q + SH_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            for (int k = 0; k < LANES; k++) crc_q[k] <= SEED;
            cnt_q   <= '0;
            len_q   <= '0;
            sh_q    <= '0;
            mode_q  <= 1'b0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        bus.busy       = (state_q != StIdle);
        bus.dout_valid = (state_q == StCrc) && !mode_q;
        bus.done       = done_q;
        bus.crc_err    = err_q;
        for (int k = 0; k < LANES; k++) begin
            bus.dout[k]                          = bus.dout_valid & crc_q[k][CRC_WIDTH-1];
            bus.crc[k*CRC_WIDTH +: CRC_WIDTH]    = crc_q[k];
        end
    end

`ifdef SDIO_CRC_ERR_COUNT_EN
    logic [7:0] err_count_q;

    // done_q and mode_q still describe the block that just finished.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_q <= 8'h00;
        end else if (done_q && mode_q && (|err_q) && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'h01;
        end
    end

    assign bus.err_count = err_count_q;
`endif
endmodule

// File: doc/sdio_crc_lanes.md
Name: sdio_crc_lanes

Overview:
- Parametrised multi-lane serial CRC engine for the SDIO data and command paths.
- Runs one independent LFSR per lane: 1 lane for CMD/DAT0, 4 lanes for 4-bit mode, 8 lanes for 8-bit mode.
- Sequences a full block itself: count data bits, then either shift the CRC out on each lane (generate) or compare the received CRC per lane (check).
- Sits between the SDIO PHY bit shifter and the data/command state machines.

Parameters:
- LANES, 4, number of parallel serial lanes (1..8).
- CRC_WIDTH, 16, CRC register width (7 for CMD, 16 for DAT).
- POLYNOMIAL, 16'h1021, generator polynomial without the top term (CRC_WIDTH bits; CRC7 uses 7'h09).
- SEED, 0, value loaded into every lane at reset and at start.
- LEN_W, 13, width of the block_len port.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse: seed all lanes, latch mode and block_len, begin a block
- mode  in  1  0 = generate/transmit, 1 = check/receive; sampled on start
- block_len  in  LEN_W  data bits per lane in the block; sampled on start
- en  in  1  bit strobe; one bit per lane is consumed or produced per strobe
- din  in  LANES  serial input bit per lane
- dout  out  LANES  serial CRC output bit per lane (generate mode, CRC phase)
- dout_valid  out  1  high while dout carries CRC bits
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last CRC bit
- crc_err  out  LANES  per-lane sticky mismatch flags (check mode); valid with done
- crc  out  LANES*CRC_WIDTH  live CRC registers; lane k occupies bits [k*CRC_WIDTH +: CRC_WIDTH]

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All CRC registers = SEED; state = IDLE.
  - dout = 0, dout_valid = 0, busy = 0, done = 0, crc_err = 0, bit counter = 0.
  - Reset overrides every other input, including mid-block.
- Per-lane update, on en in the DATA state:
  - fb = din[k] ^ crc_k[MSB]
  - crc_k <= {crc_k[CRC_WIDTH-2:0], 0} ^ (fb ? POLYNOMIAL : 0)
- IDLE:
  - On start: all lanes = SEED, crc_err cleared, counter = 0, latch mode and block_len, busy = 1.
  - Next state: DATA, or CRC if block_len = 0.
  - en in IDLE is ignored.
- DATA:
  - Each en updates all lanes and increments the counter.
  - When the counter reaches block_len on an en, move to CRC in the next cycle with the counter cleared.
- CRC, generate mode (mode = 0):
  - dout[k] = crc_k[MSB] and dout_valid = 1 for the whole state.
  - Each en shifts crc_k left with 0 fill.
  - After CRC_WIDTH strobes: state = IDLE, done = 1 for one cycle, busy = 0.
  - The CRC registers then read 0. Software reads crc before the CRC phase if the value is needed.
- CRC, check mode (mode = 1):
  - dout_valid = 0, dout = 0.
  - Each en compares din[k] with crc_k[MSB]; a mismatch sets crc_err[k] (sticky). Then crc_k shifts as in generate mode.
  - After CRC_WIDTH strobes: done pulse; crc_err holds until the next start or reset.
- start while busy: ignored; the in-flight block continues unchanged.
- Without en the state and registers hold; en may be any duty cycle.
- Latency: dout is valid in the same cycle the state enters CRC. The done pulse is registered, one cycle after the final CRC strobe.
- The counter never wraps: block_len ≤ 2^LEN_W − 1 by construction.

Optional Feature:
- Macro: SDIO_CRC_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [7:0], reset 0.
  - Increments by 1 on each done pulse, in check mode only, when any crc_err bit is set.
  - Saturates at 8'hFF.
  - Cleared only by rst_n.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- LANES=1, CRC_WIDTH=16, POLY 16'h1021, SEED 0, generate, block_len=4096, din all 1 → crc = 16'h7FA1 at end of DATA; dout serialises 0111_1111_1010_0001 MSB first; done after 16 further strobes.
- LANES=1, CRC_WIDTH=7, POLY 7'h09, generate, block_len=40, bits 0x4000000000 → crc = 7'h4A; dout emits 1001010.
- LANES=4, check mode, four identical lanes as in scenario 1, followed by correct CRC on lanes 0,1,3 and a flipped bit 5 on lane 2 → crc_err = 4'b0100 at done.
- block_len=0, generate → state goes straight to CRC, dout = SEED MSBs, done after exactly CRC_WIDTH strobes; then start again while busy → ignored, no restart.
- rst_n low mid-DATA, with en gaps of 0–3 cycles → all outputs reset values next cycle; a subsequent full block gives the same CRC as an uninterrupted run.
- With SDIO_CRC_ERR_COUNT_EN: 3 failing check blocks and 1 passing block → err_count = 3.
